// File: rtl/mac_tile_mp.sv
// Purpose: multi-precision, dual-dataflow (WS/OS) systolic processing element.
// Latency: 1 cycle in->out on every output; activations/instructions hop east 1 cycle per tile.
// Backpressure: none; tiles run in lockstep and the instruction tokens carry the flow.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   in_w / out_e     activation or weight token from west / registered copy east (a_q)
//   inst_w / inst_e  {flush, execute, load} from west / registered copy east
//   in_n / out_s     WS: psum in/out; OS: weight in, latched weight or drained result out
//   mode             0: bw x bw product; 1: two (bw/2)-bit lanes, each with its own weight
//   dataflow         0: weight-stationary; 1: output-stationary
module mac_tile_mp #(
  parameter int bw      = 4,   // even; lane width is bw/2
  parameter int psum_bw = 16   // >= 2*bw+2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s,
  input  logic               mode,
  input  logic               dataflow
);

  localparam int HB = bw / 2;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} load_state_e;

  load_state_e        state_q, state_d;
  logic [bw-1:0]      a_q, a_d;
  logic [2*bw-1:0]    b_q, b_d;
  logic [psum_bw-1:0] out_q, out_d;
  logic [psum_bw-1:0] acc_q, acc_d;
  logic [2:0]         inst_q, inst_d;
  logic               drained_q, drained_d;
  logic [2*bw-1:0]    w_os;

  // Unsigned activation lanes times signed weights, everything widened to
  // psum_bw so the sum wraps naturally. In mode 0 the high lane reuses w_lo
  // and is shifted back up, which gives the full bw x bw product.
  function automatic logic [psum_bw-1:0] prod_f(
    input logic [bw-1:0]   a,
    input logic [2*bw-1:0] w,
    input logic            m
  );
    logic signed [psum_bw-1:0] a_lo, a_hi, w_lo, w_hi, p_lo, p_hi;
    a_lo = $signed(psum_bw'(a[HB-1:0]));
    a_hi = $signed(psum_bw'(a[bw-1:HB]));
    w_lo = psum_bw'($signed(w[bw-1:0]));
    w_hi = m ? psum_bw'($signed(w[2*bw-1:bw])) : w_lo;
    p_lo = a_lo * w_lo;
    p_hi = a_hi * w_hi;
    prod_f = m ? (p_hi + p_lo) : ((p_hi <<< HB) + p_lo);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      a_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      acc_q     <= '0;
      inst_q    <= '0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_q     <= out_d;
      acc_q     <= acc_d;
      inst_q    <= inst_d;
      drained_q <= drained_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    acc_d     = acc_q;
    inst_d    = {inst_w[2], inst_w[1], 1'b0};
    drained_d = 1'b0;
    w_os      = mode ? in_n[2*bw-1:0] : {in_n[bw-1:0], in_n[bw-1:0]};

    if (inst_w[0] || inst_w[1]) begin
      a_d = in_w;
    end

    if (!dataflow) begin
      // Weight-stationary: the load FSM swallows tokens until the tile is
      // full, then lets later tokens through to the next tile east.
      if (inst_w[0]) begin
        case (state_q)
          EMPTY: begin
            if (!mode) begin
              b_d     = {in_w, in_w};
              state_d = FULL;
            end else begin
              b_d[bw-1:0] = in_w;
              state_d     = HALF;
            end
          end
          HALF: begin
            b_d[2*bw-1:bw] = in_w;
            state_d        = FULL;
          end
          FULL:    inst_d[0] = 1'b1;
          default: state_d = EMPTY;
        endcase
      end
      // Execute multiplies the incoming activation, not the stale a_q.
      if (inst_w[1]) begin
        out_d = prod_f(in_w, b_q, mode) + in_n;
      end
    end else begin
      state_d = EMPTY;
      if (inst_w[2]) begin
        // First flush cycle emits this tile's sum; later ones shift the
        // column from the north. A same-cycle execute is dropped.
        drained_d = 1'b1;
        if (!drained_q) begin
          out_d = acc_q;
          acc_d = '0;
        end else begin
          out_d = in_n;
        end
      end else if (inst_w[1]) begin
        b_d   = w_os;
        acc_d = acc_q + prod_f(in_w, w_os, mode);
        out_d = psum_bw'(w_os);
      end
    end
  end

  assign out_e  = a_q;
  assign out_s  = out_q;
  assign inst_e = inst_q;

endmodule
